frame_buffer_mig_arbiter: RTL and testbench
===========================================

FRAME_BUFFER_MIG_ARBITER -- requirements
Module: frame_buffer_mig_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 27: MIG app_addr width.
REQ-002 Parameter APP_DATA_WIDTH, default 128: MIG data width; APP_MASK_WIDTH = APP_DATA_WIDTH/8.
REQ-003 Parameter BURST_STEP, default 8: address increment per burst.
REQ-004 Parameter CNT_WIDTH, default 8: width of burst counts.
REQ-005 clk  in  1  the only clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 init_calib_complete  in  1  MIG calibration done.
REQ-008 wr_req / wr_addr / wr_bursts  in  1 / ADDR_WIDTH / CNT_WIDTH  scanline flush request, base address and burst count; held stable until wr_done.
REQ-009 wr_data  in  APP_DATA_WIDTH  current write beat (4 RGBA8 pixels).
REQ-010 wr_data_pop  out  1  one-cycle pulse per consumed beat; the writer presents the next beat on the following cycle.
REQ-011 wr_done  out  1  one-cycle pulse when the write transaction completes.
REQ-012 rd_req / rd_addr / rd_bursts  in  1 / ADDR_WIDTH / CNT_WIDTH  display fetch request, held until rd_done.
REQ-013 rd_data / rd_data_valid  out  APP_DATA_WIDTH / 1  returned read beats, in order.
REQ-014 rd_done  out  1  one-cycle pulse when the last read beat is returned.
REQ-015 app_en, app_cmd[2:0], app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask  out  MIG user-interface command and write-data outputs.
REQ-016 app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid  in  MIG user-interface acceptance and read-return inputs.

Function
REQ-017 States are IDLE, WRITE, READ; the state is registered.
REQ-018 IDLE: no grant while init_calib_complete=0.
REQ-019 IDLE arbitration with only one request pending: grant that request.
REQ-020 IDLE arbitration with both requests pending: grant the requester not served last; after reset, READ wins the first tie.
REQ-021 On grant: cmd_addr <= base address, issued <= 0, completed <= 0; the request is sampled only in IDLE.
REQ-022 A request with a burst count of 0 completes in one cycle: it pulses its done signal, makes no MIG access and returns to IDLE.
REQ-023 Command accept = app_en & app_rdy. On each accept, cmd_addr += BURST_STEP (modulo 2^ADDR_WIDTH) and issued += 1.
REQ-024 app_en=1 while issued < count; app_en holds with stable app_addr/app_cmd until accepted.
REQ-025 WRITE: app_cmd=3'b000; READ: app_cmd=3'b001.
REQ-026 WRITE data path: app_wdf_wren=1 while written < count; app_wdf_end = app_wdf_wren; app_wdf_data = wr_data; app_wdf_mask = 0.
REQ-027 Write beat accept = app_wdf_wren & app_wdf_rdy; it increments written and drives wr_data_pop=1 in the same cycle.
REQ-028 The command and data channels of a write advance independently, and they may accept in the same cycle.
REQ-029 WRITE completes when issued == written == count; on that cycle pulse wr_done and go to IDLE.
REQ-030 READ: each app_rd_data_valid increments returned, and rd_data/rd_data_valid mirror app_rd_data/app_rd_data_valid, registered with 1-cycle latency.
REQ-031 READ completes when returned == count. rd_done pulses in the same cycle as the final rd_data_valid, then the state returns to IDLE.
REQ-032 app_rd_data_valid arriving outside READ is ignored and is not forwarded.
REQ-033 A done pulse is followed by at least one IDLE cycle before the next grant.
REQ-034 If init_calib_complete drops mid-transaction, the transaction continues; only new grants are blocked.
REQ-035 Counters are CNT_WIDTH+1 bits wide, so a count of 2^CNT_WIDTH-1 does not overflow.

Reset
REQ-036 Reset forces state=IDLE, last-served=WRITE (so READ wins the first tie), and clears all counters.
REQ-037 During reset: app_en=0, app_wdf_wren=0, app_wdf_end=0, app_cmd=0, app_addr=0, app_wdf_data=0, app_wdf_mask=0, wr_data_pop=0, wr_done=0, rd_data_valid=0, rd_done=0, rd_data=0.
REQ-038 Reset mid-transaction aborts it immediately: no done pulse; MIG commands already accepted are not tracked.

Verification
REQ-039 Write only: wr_req with wr_addr=0x008, wr_bursts=4, app_rdy=app_wdf_rdy=1 -> app_addr 0x008, 0x010, 0x018, 0x020 on consecutive cycles; 4 wr_data_pop pulses; wr_done on the 4th accept cycle.
REQ-040 Backpressure: wr_bursts=2, app_rdy low 3 cycles, app_wdf_rdy low 5 cycles -> app_en and app_addr stay stable while stalled; exactly 2 commands and 2 beats are accepted; wr_done follows the last accept.
REQ-041 Read with returns: rd_addr=0x100, rd_bursts=3; MIG returns 3 beats 10 cycles later -> 3 rd_data_valid pulses, each one cycle after its app_rd_data_valid; rd_done with the third.
REQ-042 Tie and fairness: wr_req and rd_req both held after reset -> READ, then WRITE, then READ; no requester is granted twice in a row while the other is pending.
REQ-043 Calibration gating and zero count: init_calib_complete=0 with wr_req -> no app_en; after calibration, wr_bursts=0 -> wr_done next cycle and no MIG access.
REQ-044 Reset mid-write after 2 of 4 accepts -> all outputs 0 next cycle, no wr_done; a new request after reset starts from its own base address.

Source files
------------

// File: rtl/frame_buffer_mig_arbiter_if.sv
// Frame buffer <-> MIG arbiter bus bundle.
// Scanline writer, display reader and MIG user interface signals.
interface frame_buffer_mig_arbiter_if #(
  parameter int ADDR_WIDTH     = 27,
  parameter int APP_DATA_WIDTH = 128,
  parameter int CNT_WIDTH      = 8
);
  localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8;

  logic                      wr_req;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [CNT_WIDTH-1:0]      wr_bursts;
  logic [APP_DATA_WIDTH-1:0] wr_data;
  logic                      wr_data_pop;
  logic                      wr_done;

  logic                      rd_req;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [CNT_WIDTH-1:0]      rd_bursts;
  logic [APP_DATA_WIDTH-1:0] rd_data;
  logic                      rd_data_valid;
  logic                      rd_done;

  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_rdy;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;

  modport master (
    input  wr_req, wr_addr, wr_bursts, wr_data,
    input  rd_req, rd_addr, rd_bursts,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid,
    output wr_data_pop, wr_done,
    output rd_data, rd_data_valid, rd_done,
    output app_en, app_cmd, app_addr,
    output app_wdf_wren, app_wdf_end,
    output app_wdf_data, app_wdf_mask
  );

  modport slave (
    output wr_req, wr_addr, wr_bursts, wr_data,
    output rd_req, rd_addr, rd_bursts,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_valid,
    input  wr_data_pop, wr_done,
    input  rd_data, rd_data_valid, rd_done,
    input  app_en, app_cmd, app_addr,
    input  app_wdf_wren, app_wdf_end,
    input  app_wdf_data, app_wdf_mask
  );
endinterface

// File: rtl/frame_buffer_mig_arbiter.sv
// Frame buffer MIG arbiter: scanline writes vs display reads.
// One transaction at a time, alternating grants on a tie.
module frame_buffer_mig_arbiter #(
  parameter int ADDR_WIDTH     = 27,
  parameter int APP_DATA_WIDTH = 128,
  parameter int BURST_STEP     = 8,
  parameter int CNT_WIDTH      = 8
) (
  input logic clk,
  input logic reset,
  input logic init_calib_complete,
  frame_buffer_mig_arbiter_if.master bus
);
  localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8;
  localparam int CW = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                      r_last_wr;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             r_issued;
  logic [CW-1:0]             r_written;
  logic [CW-1:0]             r_returned;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_rd_valid;
  logic [APP_DATA_WIDTH-1:0] r_rd_data;

  logic          w_grant_wr;
  logic          w_grant_rd;
  logic          w_app_en;
  logic          w_wdf_wren;
  logic          w_cmd_acc;
  logic          w_wdf_acc;
  logic          w_ret;
  logic          w_wr_done;
  logic          w_rd_done;
  logic [CW-1:0] w_iss_nx;
  logic [CW-1:0] w_wrt_nx;

  // Next state, grant decision and channel enables.
  always_comb begin
    w_next     = r_state;
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    w_app_en   = 1'b0;
    w_wdf_wren = 1'b0;
    w_ret      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (init_calib_complete) begin
          if (bus.wr_req && bus.rd_req) begin
            w_grant_rd = r_last_wr;
            w_grant_wr = ~r_last_wr;
          end else begin
            w_grant_wr = bus.wr_req;
            w_grant_rd = bus.rd_req;
          end
        end
        if (w_grant_wr) w_next = S_WRITE;
        if (w_grant_rd) w_next = S_READ;
      end
      S_WRITE: begin
        w_app_en   = r_issued < r_cnt;
        w_wdf_wren = r_written < r_cnt;
      end
      S_READ: begin
        w_app_en = r_issued < r_cnt;
        w_ret    = bus.app_rd_data_valid
                 && (r_returned < r_cnt);
      end
      default: w_next = S_IDLE;
    endcase
    w_cmd_acc = w_app_en & bus.app_rdy;
    w_wdf_acc = w_wdf_wren & bus.app_wdf_rdy;
    w_iss_nx  = r_issued + CW'(w_cmd_acc);
    w_wrt_nx  = r_written + CW'(w_wdf_acc);
    w_wr_done = (r_state == S_WRITE)
              && (w_iss_nx == r_cnt)
              && (w_wrt_nx == r_cnt);
    w_rd_done = (r_state == S_READ)
              && (r_returned == r_cnt);
    if (w_wr_done || w_rd_done) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Transaction counters, command address and read return stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_wr  <= 1'b1;
      r_cnt      <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_returned <= '0;
      r_addr     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_ret;
      if (w_ret) r_rd_data <= bus.app_rd_data;
      if (w_grant_wr) begin
        r_last_wr  <= 1'b1;
        r_addr     <= bus.wr_addr;
        r_cnt      <= {1'b0, bus.wr_bursts};
        r_issued   <= '0;
        r_written  <= '0;
        r_returned <= '0;
      end else if (w_grant_rd) begin
        r_last_wr  <= 1'b0;
        r_addr     <= bus.rd_addr;
        r_cnt      <= {1'b0, bus.rd_bursts};
        r_issued   <= '0;
        r_written  <= '0;
        r_returned <= '0;
      end else begin
        if (w_cmd_acc) begin
          r_addr <= r_addr + ADDR_WIDTH'(BURST_STEP);
        end
        r_issued  <= w_iss_nx;
        r_written <= w_wrt_nx;
        if (w_ret) r_returned <= r_returned + 1'b1;
      end
    end
  end

  assign bus.app_en       = ~reset & w_app_en;
  assign bus.app_cmd      = (reset || r_state != S_READ)
                          ? 3'b000 : 3'b001;
  assign bus.app_addr     = reset ? '0 : r_addr;
  assign bus.app_wdf_wren = ~reset & w_wdf_wren;
  assign bus.app_wdf_end  = ~reset & w_wdf_wren;
  assign bus.app_wdf_data = reset ? '0 : bus.wr_data;
  assign bus.app_wdf_mask = {APP_MASK_WIDTH{1'b0}};
  assign bus.wr_data_pop  = ~reset & w_wdf_acc;
  assign bus.wr_done      = ~reset & w_wr_done;
  assign bus.rd_done      = ~reset & w_rd_done;
  assign bus.rd_data_valid = ~reset & r_rd_valid;
  assign bus.rd_data      = reset ? '0 : r_rd_data;
endmodule

// File: tb/tb_frame_buffer_mig_arbiter.sv
// Bench for frame_buffer_mig_arbiter.
// Transaction-level model, directed scenarios and random traffic.
module tb_frame_buffer_mig_arbiter;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int STEP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic calib = 1'b0;

  always #5 clk = ~clk;

  frame_buffer_mig_arbiter_if #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) bus ();

  frame_buffer_mig_arbiter #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW),
    .BURST_STEP(STEP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_calib_complete(calib),
    .bus(bus.master)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // model: 0 idle, 1 write, 2 read
  int m_kind = 0;
  logic [AW-1:0] m_base;
  int m_cnt, m_iss, m_wrt, m_ret;
  bit m_last_wr = 1'b1;
  bit m_fv = 1'b0;
  logic [DW-1:0] m_fd;

  int ret_q[$];
  int ret_delay = -1;
  bit rnd_bp = 1'b0;
  bit spur = 1'b0;
  int done_log[$];
  logic [AW-1:0] addr_log[$];
  int n_pop, n_cacc, n_rdv, n_en, n_wd;
  bit s_wd, s_rdn, s_pop, s_rdv, s_cacc, s_racc;
  logic [AW-1:0] s_addr;

  function automatic logic [DW-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h",
                  nm, act, exp);
  endtask

  task automatic model_cmp();
    bit e_en, e_wren, e_pop, e_wd, e_rdn, e_ret, cacc, gw;
    logic [AW-1:0] e_addr;
    if (reset) begin
      chk("rst_app_en", bus.app_en, 0);
      chk("rst_app_cmd", bus.app_cmd, 0);
      chk("rst_app_addr", bus.app_addr, 0);
      chk("rst_wdf_wren", bus.app_wdf_wren, 0);
      chk("rst_wdf_end", bus.app_wdf_end, 0);
      chk("rst_wdf_data", bus.app_wdf_data, 0);
      chk("rst_wdf_mask", bus.app_wdf_mask, 0);
      chk("rst_wr_pop", bus.wr_data_pop, 0);
      chk("rst_wr_done", bus.wr_done, 0);
      chk("rst_rd_valid", bus.rd_data_valid, 0);
      chk("rst_rd_done", bus.rd_done, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      m_kind = 0;
      m_last_wr = 1'b1;
      m_fv = 1'b0;
      return;
    end
    e_en = 0; e_wren = 0; e_pop = 0; e_wd = 0;
    e_rdn = 0; e_ret = 0; cacc = 0;
    e_addr = m_base + AW'(m_iss * STEP);
    if (m_kind == 1) begin
      e_en = m_iss < m_cnt;
      e_wren = m_wrt < m_cnt;
      e_pop = e_wren && bus.app_wdf_rdy;
      cacc = e_en && bus.app_rdy;
      e_wd = (m_iss + int'(cacc) == m_cnt)
          && (m_wrt + int'(e_pop) == m_cnt);
    end else if (m_kind == 2) begin
      e_en = m_iss < m_cnt;
      cacc = e_en && bus.app_rdy;
      e_ret = bus.app_rd_data_valid && (m_ret < m_cnt);
      e_rdn = m_ret == m_cnt;
    end
    chk("app_en", bus.app_en, e_en);
    chk("wdf_wren", bus.app_wdf_wren, e_wren);
    chk("wdf_end", bus.app_wdf_end, e_wren);
    chk("wr_pop", bus.wr_data_pop, e_pop);
    chk("wr_done", bus.wr_done, e_wd);
    chk("rd_done", bus.rd_done, e_rdn);
    chk("rd_valid", bus.rd_data_valid, m_fv);
    chk("wdf_mask", bus.app_wdf_mask, 0);
    if (e_en) begin
      chk("app_addr", bus.app_addr, e_addr);
      chk("app_cmd", bus.app_cmd, (m_kind == 2) ? 1 : 0);
    end
    if (e_wren) chk("wdf_data", bus.app_wdf_data, bus.wr_data);
    if (m_fv) chk("rd_data", bus.rd_data, m_fd);
    m_fv = e_ret;
    m_fd = bus.app_rd_data;
    if (m_kind == 0) begin
      if (calib && (bus.wr_req || bus.rd_req)) begin
        gw = bus.wr_req && !(bus.rd_req && m_last_wr);
        m_kind = gw ? 1 : 2;
        m_base = gw ? bus.wr_addr : bus.rd_addr;
        m_cnt = gw ? int'(bus.wr_bursts) : int'(bus.rd_bursts);
        m_iss = 0; m_wrt = 0; m_ret = 0;
        m_last_wr = gw;
      end
    end else if (e_wd || e_rdn) begin
      m_kind = 0;
    end else begin
      m_iss += int'(cacc);
      m_wrt += int'(e_pop);
      m_ret += int'(e_ret);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_pop = bus.wr_data_pop;
    s_wd = bus.wr_done;
    s_rdn = bus.rd_done;
    s_rdv = bus.rd_data_valid;
    s_cacc = bus.app_en & bus.app_rdy;
    s_racc = s_cacc && (bus.app_cmd == 3'b001);
    s_addr = bus.app_addr;
    n_en += int'(bus.app_en);
    model_cmp();
    @(posedge clk);
    #1;
    cyc++;
    n_pop += int'(s_pop);
    n_cacc += int'(s_cacc);
    n_rdv += int'(s_rdv);
    n_wd += int'(s_wd);
    if (s_cacc) addr_log.push_back(s_addr);
    if (s_pop) bus.wr_data = r128();
    if (s_wd) begin bus.wr_req = 1'b0; done_log.push_back(1); end
    if (s_rdn) begin bus.rd_req = 1'b0; done_log.push_back(2); end
    if (reset) ret_q.delete();
    else if (s_racc)
      ret_q.push_back(cyc + ((ret_delay >= 0) ? ret_delay - 1
                                              : $urandom_range(0, 6)));
    bus.app_rd_data_valid = 1'b0;
    if (ret_q.size() > 0 && ret_q[0] <= cyc &&
        (ret_delay >= 0 || $urandom % 4 != 0)) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data = r128();
      void'(ret_q.pop_front());
    end else if (spur && m_kind == 0 && ret_q.size() == 0
                 && $urandom % 6 == 0) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data = r128();
    end
    if (rnd_bp) begin
      bus.app_rdy = ($urandom % 4) != 0;
      bus.app_wdf_rdy = ($urandom % 3) != 0;
    end
  endtask

  task automatic wait_done(input int kind, input int bound,
                           output int steps);
    bit seen;
    seen = 1'b0;
    steps = 0;
    while (!seen && steps < bound) begin
      step();
      steps++;
      seen = (kind == 1) ? s_wd : s_rdn;
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    int st;
    logic [AW-1:0] exp4[4];
    exp4 = '{27'h008, 27'h010, 27'h018, 27'h020};
    bus.wr_req = 0; bus.wr_addr = 0; bus.wr_bursts = 0;
    bus.wr_data = r128();
    bus.rd_req = 0; bus.rd_addr = 0; bus.rd_bursts = 0;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    bus.app_rd_data = 0; bus.app_rd_data_valid = 0;
    repeat (3) step();
    reset = 0;

    // calibration gating, then zero-length write
    bus.wr_req = 1; bus.wr_addr = 27'h40; bus.wr_bursts = 2;
    n_en = 0;
    repeat (6) step();
    chk("no_en_uncal", n_en, 0);
    bus.wr_bursts = 0; calib = 1; n_en = 0;
    wait_done(1, 10, st);
    chk("zero_done_lat", st, 2);
    chk("zero_no_access", n_en, 0);

    // plain 4-burst write
    addr_log.delete(); n_pop = 0;
    bus.wr_req = 1; bus.wr_addr = 27'h008; bus.wr_bursts = 4;
    wait_done(1, 20, st);
    chk("wr4_lat", st, 5);
    chk("wr4_pops", n_pop, 4);
    chk("wr4_done_on_acc", s_cacc & s_pop, 1);
    chk("wr4_nacc", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size()) chk("wr4_addr", addr_log[i], exp4[i]);

    // backpressure on both write channels
    n_cacc = 0; n_pop = 0;
    bus.wr_req = 1; bus.wr_addr = 27'h1000; bus.wr_bursts = 2;
    step();
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    for (int k = 0; k < 20 && !s_wd; k++) begin
      step();
      bus.app_rdy = k >= 2;
      bus.app_wdf_rdy = k >= 4;
    end
    chk("bp_done_seen", s_wd, 1);
    chk("bp_cmds", n_cacc, 2);
    chk("bp_beats", n_pop, 2);
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;

    // 3-burst read, returns 10 cycles after each command
    ret_delay = 10; n_rdv = 0;
    bus.rd_req = 1; bus.rd_addr = 27'h100; bus.rd_bursts = 3;
    wait_done(2, 40, st);
    chk("rd3_lat", st, 15);
    chk("rd3_nvalid", n_rdv, 3);
    chk("rd3_done_with_valid", s_rdv, 1);
    ret_delay = -1;

    // reset in the middle of a write
    n_cacc = 0; n_wd = 0;
    bus.wr_req = 1; bus.wr_addr = 27'h200; bus.wr_bursts = 4;
    repeat (3) step();
    reset = 1; bus.wr_req = 0;
    step();
    reset = 0;
    step();
    chk("rst_mid_cmds", n_cacc, 2);
    chk("rst_mid_no_done", n_wd, 0);
    addr_log.delete();
    bus.wr_req = 1; bus.wr_addr = 27'h300; bus.wr_bursts = 1;
    wait_done(1, 20, st);
    chk("post_rst_nacc", addr_log.size(), 1);
    if (addr_log.size() > 0)
      chk("post_rst_addr", addr_log[0], 27'h300);

    // tie after reset: read, write, read
    reset = 1;
    step();
    bus.wr_req = 1; bus.wr_addr = 27'h400; bus.wr_bursts = 2;
    bus.rd_req = 1; bus.rd_addr = 27'h500; bus.rd_bursts = 2;
    step();
    reset = 0;
    done_log.delete();
    for (int k = 0; k < 300 && done_log.size() < 3; k++) begin
      step();
      if (!bus.wr_req) bus.wr_req = 1;
      if (!bus.rd_req) bus.rd_req = 1;
    end
    chk("tie_ndone", done_log.size() >= 3, 1);
    if (done_log.size() >= 3) begin
      chk("tie_first", done_log[0], 2);
      chk("tie_second", done_log[1], 1);
      chk("tie_third", done_log[2], 2);
    end
    bus.rd_req = 0;
    wait_done(1, 50, st);

    // max count write with address wrap and random stalls
    rnd_bp = 1;
    bus.wr_req = 1; bus.wr_addr = 27'h7FFFF00; bus.wr_bursts = 255;
    wait_done(1, 3000, st);

    // random traffic
    spur = 1;
    for (int k = 0; k < 4000; k++) begin
      step();
      reset = ($urandom % 500) == 0;
      calib = ($urandom % 16) != 0;
      if (!bus.wr_req && $urandom % 5 == 0) begin
        bus.wr_req = 1;
        bus.wr_addr = ($urandom % 4 == 0) ? 27'h7FFFFF0 : AW'($urandom);
        bus.wr_bursts = CW'($urandom_range(0, 6));
      end
      if (!bus.rd_req && $urandom % 5 == 0) begin
        bus.rd_req = 1;
        bus.rd_addr = ($urandom % 4 == 0) ? 27'h7FFFFF8 : AW'($urandom);
        bus.rd_bursts = CW'($urandom_range(0, 6));
      end
    end

    // drain outstanding requests
    reset = 0; calib = 1; spur = 0; rnd_bp = 0;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    for (int k = 0; k < 3000 && (bus.wr_req || bus.rd_req); k++)
      step();
    chk("drain_idle", bus.wr_req | bus.rd_req, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
